// File: rtl/canny_pkg.sv
// Shared definitions for the Canny edge pipeline: image geometry, window
// geometry, pixel type and the window loader state encoding.
package canny_pkg;

    localparam int IMG_WIDTH   = 32;                        // pixels per row, also window row pitch
    localparam int IMG_HEIGHT  = 32;                        // rows per frame
    localparam int WIN_ROWS    = 5;                         // kernel height
    localparam int PIX_W       = 8;                         // pixel width in bits
    localparam int WIN_SIZE    = WIN_ROWS * IMG_WIDTH;      // 160 pixels per window
    localparam int SHIFT_LEN   = WIN_SIZE - IMG_WIDTH;      // pixels kept on a slide (128)
    localparam int NUM_WINDOWS = IMG_HEIGHT - WIN_ROWS + 1; // windows per frame (28)

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [7:0]       idx_t;       // write index into the window, 0..159
    typedef logic [4:0]       win_cnt_t;   // windows consumed in the current frame

    typedef enum logic [2:0] {
        S_FILL,
        S_START,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } loader_state_t;

endpackage

// File: rtl/conv_window_loader.sv
// Window loader feeding the 5x5 Gaussian stage. Assembles a 5-row window from
// a raster pixel stream, hands it to the convolution stage with a startConv
// pulse, holds it until convDone rises, then slides it down one image row.
module conv_window_loader
    import canny_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   pix_valid,
    input  pixel_t pix_in,
    input  logic   sof,
    output logic   pix_ready,
    output logic   startConv,
    input  logic   convDone,
    output pixel_t bufferInput [0:WIN_SIZE-1],
    output logic   frame_done
);

    localparam idx_t     LAST_IDX   = idx_t'(WIN_SIZE - 1);
    localparam idx_t     REFILL_IDX = idx_t'(SHIFT_LEN);
    localparam win_cnt_t LAST_WIN   = win_cnt_t'(NUM_WINDOWS - 1);

    loader_state_t state;
    idx_t          wrIdx;
    win_cnt_t      winCnt;
    logic          convDonePrev;
    logic          accept;
    logic          convDoneRise;

    // The loader only takes pixels while filling; held low throughout reset.
    assign pix_ready    = (state == S_FILL) && !reset;
    assign accept       = pix_valid && pix_ready;
    assign convDoneRise = convDone && !convDonePrev;

    // Track convDone in every state so a level already high on entry to S_WAIT is not seen as a new edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            convDonePrev <= 1'b0;
        end else begin
            convDonePrev <= convDone;
        end
    end

    // Window FSM: fill, announce, wait for the convolution stage, slide or close the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FILL;
            wrIdx      <= '0;
            winCnt     <= '0;
            startConv  <= 1'b0;
            frame_done <= 1'b0;
            // NOTE: the window is a visible output that must read all-zero after reset, so unlike a plain RAM every entry is cleared here.
            for (int i = 0; i < WIN_SIZE; i++) begin
                bufferInput[i] <= '0;
            end
        end else begin
            startConv  <= 1'b0;
            frame_done <= 1'b0;

            unique case (state)
                S_FILL: begin
                    if (accept) begin
                        if (sof) begin
                            // New frame restarts the window from scratch.
                            bufferInput[0] <= pix_in;
                            wrIdx          <= idx_t'(1);
                            winCnt         <= '0;
                        end else begin
                            bufferInput[wrIdx] <= pix_in;
                            if (wrIdx == LAST_IDX) begin
                                state     <= S_START;
                                startConv <= 1'b1;
                            end else begin
                                wrIdx <= wrIdx + 1'b1;
                            end
                        end
                    end
                end

                S_START: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (convDoneRise) begin
                        winCnt <= winCnt + 1'b1;
                        if (winCnt == LAST_WIN) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end

                S_SHIFT: begin
                    // Drop the oldest row; the bottom row is refilled from the stream.
                    for (int i = 0; i < SHIFT_LEN; i++) begin
                        bufferInput[i] <= bufferInput[i + IMG_WIDTH];
                    end
                    wrIdx <= REFILL_IDX;
                    state <= S_FILL;
                end

                S_DONE: begin
                    wrIdx  <= '0;
                    winCnt <= '0;
                    state  <= S_FILL;
                end

                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_loader.sv
// Self-checking bench for conv_window_loader. The reference model keeps every
// pixel accepted since the start of the frame; window w of a frame is simply
// pixels [w*IMG_WIDTH .. w*IMG_WIDTH+WIN_SIZE-1] of that list.
module tb_conv_window_loader;
    import canny_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    logic   pix_valid;
    pixel_t pix_in;
    logic   sof;
    logic   pix_ready;
    logic   startConv;
    logic   convDone;
    pixel_t bufferInput [0:WIN_SIZE-1];
    logic   frame_done;

    conv_window_loader dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_in      (pix_in),
        .sof         (sof),
        .pix_ready   (pix_ready),
        .startConv   (startConv),
        .convDone    (convDone),
        .bufferInput (bufferInput),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int nChecks  = 0;
    int nFails   = 0;
    int startCnt = 0;
    int doneCnt  = 0;

    // Reference model: pixels of the current frame, and index of the window being built.
    pixel_t frm[$];
    int     winIdx = 0;

    // Pulse counters, sampled on the rising edge that ends each pulse.
    always @(posedge clk) begin
        if (!reset) begin
            if (startConv)  startCnt++;
            if (frame_done) doneCnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Offer one pixel and wait (bounded) for it to be accepted; checks startConv timing and window contents.
    task automatic send(input pixel_t p, input logic s);
        int   waitCyc = 0;
        logic expStart;
        int   bad = 0;
        int   firstBad = -1;
        pix_valid = 1'b1;
        pix_in    = p;
        sof       = s;
        while (!pix_ready && waitCyc < 100) begin
            @(negedge clk);
            waitCyc++;
        end
        if (!pix_ready) begin
            nChecks++;
            nFails++;
            $display("FAIL send_ready_timeout: pix_ready=%0b after %0d cycles, required 1", pix_ready, waitCyc);
            pix_valid = 1'b0;
            sof       = 1'b0;
            return;
        end
        @(negedge clk);
        pix_valid = 1'b0;
        sof       = 1'b0;
        if (s) begin
            frm.delete();
            winIdx = 0;
        end
        frm.push_back(p);
        expStart = (frm.size() == WIN_SIZE + IMG_WIDTH * winIdx);
        nChecks++;
        if (startConv !== expStart) begin
            nFails++;
            $display("FAIL start_timing: startConv=%0b after pixel %0d of frame, required %0b", startConv, frm.size(), expStart);
        end
        if (expStart) begin
            for (int k = 0; k < WIN_SIZE; k++) begin
                if (bufferInput[k] !== frm[winIdx * IMG_WIDTH + k]) begin
                    if (firstBad < 0) firstBad = k;
                    bad++;
                end
            end
            nChecks++;
            if (bad != 0) begin
                nFails++;
                $display("FAIL window_contents: %0d entries differ, first [%0d] got %h required %h",
                         bad, firstBad, bufferInput[firstBad], frm[winIdx * IMG_WIDTH + firstBad]);
            end
            nChecks++;
            if (pix_ready !== 1'b0) begin
                nFails++;
                $display("FAIL ready_in_start: pix_ready=%0b, required 0", pix_ready);
            end
        end
    endtask

    // Play the convolution stage: wait, raise convDone for 'hold' cycles, check slide or frame end.
    task automatic finish_conv(input int delay, input int hold);
        logic lastWin;
        int   bad = 0;
        int   firstBad = -1;
        pixel_t expPix;
        repeat (delay) @(negedge clk);
        nChecks++;
        if (startConv !== 1'b0 || pix_ready !== 1'b0) begin
            nFails++;
            $display("FAIL wait_state: startConv=%0b pix_ready=%0b, required 0 0", startConv, pix_ready);
        end
        convDone = 1'b1;
        @(negedge clk);
        winIdx++;
        lastWin = (winIdx == NUM_WINDOWS);
        nChecks++;
        if (frame_done !== lastWin) begin
            nFails++;
            $display("FAIL frame_done_pulse: frame_done=%0b after window %0d, required %0b", frame_done, winIdx, lastWin);
        end
        repeat (hold - 1) @(negedge clk);
        convDone = 1'b0;
        if (hold == 1) @(negedge clk);
        nChecks++;
        if (pix_ready !== 1'b1) begin
            nFails++;
            $display("FAIL ready_after_conv: pix_ready=%0b, required 1", pix_ready);
        end
        if (lastWin) begin
            frm.delete();
            winIdx = 0;
        end else begin
            for (int k = 0; k < WIN_SIZE; k++) begin
                expPix = (k < SHIFT_LEN) ? frm[winIdx * IMG_WIDTH + k] : frm[(winIdx - 1) * IMG_WIDTH + k];
                if (bufferInput[k] !== expPix) begin
                    if (firstBad < 0) firstBad = k;
                    bad++;
                end
            end
            nChecks++;
            if (bad != 0) begin
                nFails++;
                $display("FAIL slid_window: %0d entries differ, first at [%0d] got %h", bad, firstBad, bufferInput[firstBad]);
            end
        end
    endtask

    // Hold reset for two cycles and check every output is cleared; release leaves pix_ready high.
    task automatic apply_reset(input string tag);
        int bad = 0;
        @(negedge clk);
        reset     = 1'b1;
        pix_valid = 1'b0;
        sof       = 1'b0;
        convDone  = 1'b0;
        frm.delete();
        winIdx = 0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < WIN_SIZE; k++) if (bufferInput[k] !== '0) bad++;
        nChecks++;
        if (bad != 0) begin
            nFails++;
            $display("FAIL %s_buffer_clear: %0d nonzero window entries, required 0", tag, bad);
        end
        nChecks++;
        if (startConv !== 1'b0 || frame_done !== 1'b0 || pix_ready !== 1'b0) begin
            nFails++;
            $display("FAIL %s_outputs: startConv=%0b frame_done=%0b pix_ready=%0b, required 0 0 0",
                     tag, startConv, frame_done, pix_ready);
        end
        reset = 1'b0;
        #1;
        nChecks++;
        if (pix_ready !== 1'b1) begin
            nFails++;
            $display("FAIL %s_ready_release: pix_ready=%0b, required 1", tag, pix_ready);
        end
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_first_window();
        int s0;
        apply_reset("first_window");
        s0 = startCnt;
        for (int k = 0; k < WIN_SIZE; k++) send(pixel_t'(k), 1'b0);
        @(negedge clk);
        nChecks++;
        if (startCnt - s0 !== 1) begin
            nFails++;
            $display("FAIL first_window_pulses: %0d startConv pulses, required 1", startCnt - s0);
        end
    endtask

    // Continues from the first window: slide once, then fill the next row.
    task automatic test_slide();
        int s0;
        finish_conv(3, 2);
        nChecks++;
        if (bufferInput[0] !== 8'd32 || bufferInput[127] !== 8'd159) begin
            nFails++;
            $display("FAIL slide_endpoints: [0]=%0d [127]=%0d, required 32 159", bufferInput[0], bufferInput[127]);
        end
        s0 = startCnt;
        for (int k = 160; k < 192; k++) send(pixel_t'(k), 1'b0);
        @(negedge clk);
        nChecks++;
        if (startCnt - s0 !== 1) begin
            nFails++;
            $display("FAIL slide_pulses: %0d startConv pulses, required 1", startCnt - s0);
        end
    endtask

    // Continues in S_WAIT: pixels offered while waiting must be refused.
    task automatic test_backpressure();
        int s0;
        int bad = 0;
        s0 = startCnt;
        for (int c = 0; c < 8; c++) begin
            pix_valid = 1'b1;
            pix_in    = 8'hAA;
            @(negedge clk);
            nChecks++;
            if (pix_ready !== 1'b0) begin
                nFails++;
                $display("FAIL backpressure_ready: pix_ready=%0b in cycle %0d, required 0", pix_ready, c);
            end
        end
        pix_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < WIN_SIZE; k++) if (bufferInput[k] !== frm[winIdx * IMG_WIDTH + k]) bad++;
        nChecks++;
        if (bad != 0 || startCnt !== s0) begin
            nFails++;
            $display("FAIL backpressure_hold: %0d entries changed, %0d extra startConv, required 0 0", bad, startCnt - s0);
        end
    endtask

    task automatic test_full_frame();
        int s0;
        int d0;
        apply_reset("full_frame");
        s0 = startCnt;
        d0 = doneCnt;
        for (int row = 0; row < IMG_HEIGHT; row++) begin
            for (int col = 0; col < IMG_WIDTH; col++) begin
                if ($urandom_range(0, 7) == 0) @(negedge clk);
                send(pixel_t'($urandom), 1'b0);
            end
            if (row >= WIN_ROWS - 1) finish_conv(30, int'($urandom_range(1, 3)));
        end
        nChecks++;
        if (startCnt - s0 !== NUM_WINDOWS || doneCnt - d0 !== 1) begin
            nFails++;
            $display("FAIL full_frame_pulses: startConv=%0d frame_done=%0d, required %0d 1",
                     startCnt - s0, doneCnt - d0, NUM_WINDOWS);
        end
        @(negedge clk);
        nChecks++;
        if (pix_ready !== 1'b1 || frame_done !== 1'b0) begin
            nFails++;
            $display("FAIL full_frame_idle: pix_ready=%0b frame_done=%0b, required 1 0", pix_ready, frame_done);
        end
    endtask

    task automatic test_sof_restart();
        int s0;
        apply_reset("sof");
        s0 = startCnt;
        for (int k = 0; k < 70; k++) send(pixel_t'($urandom), 1'b0);
        send(8'h55, 1'b1);
        nChecks++;
        if (bufferInput[0] !== 8'h55) begin
            nFails++;
            $display("FAIL sof_first_pixel: [0]=%h, required 55", bufferInput[0]);
        end
        for (int k = 1; k < WIN_SIZE; k++) send(pixel_t'($urandom), 1'b0);
        @(negedge clk);
        nChecks++;
        if (startCnt - s0 !== 1) begin
            nFails++;
            $display("FAIL sof_pulses: %0d startConv pulses, required 1", startCnt - s0);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        int d0;
        apply_reset("mid_setup");
        s0 = startCnt;
        for (int k = 0; k < 100; k++) send(pixel_t'($urandom), 1'b0);
        apply_reset("mid_fill");
        for (int k = 0; k < WIN_SIZE; k++) send(pixel_t'($urandom), 1'b0);
        @(negedge clk);
        nChecks++;
        if (startCnt - s0 !== 1) begin
            nFails++;
            $display("FAIL mid_fill_refill: %0d startConv pulses, required 1", startCnt - s0);
        end
        s0 = startCnt;
        d0 = doneCnt;
        apply_reset("mid_wait");
        repeat (3) @(negedge clk);
        nChecks++;
        if (startCnt !== s0 || doneCnt !== d0) begin
            nFails++;
            $display("FAIL mid_wait_pulses: startConv=%0d frame_done=%0d extra, required 0 0", startCnt - s0, doneCnt - d0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_in    = '0;
        sof       = 1'b0;
        convDone  = 1'b0;
        test_reset();
        test_first_window();
        test_slide();
        test_backpressure();
        test_full_frame();
        test_sof_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
